wb_byte_loader: RTL and testbench
=================================

WB_BYTE_LOADER -- requirements
Module: wb_byte_loader

Interface
REQ-001 Parameter BASE_ADR, default 32'h0000_0000, byte address of the first word written; SHALL be word-aligned.
REQ-002 Parameter WORDS, default 256, target memory depth in 32-bit words; SHALL be a power of two.
REQ-003 wb_clk_i  in  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-004 wb_rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-005 start_i  in  1  single-cycle load request.
REQ-006 len_i  in  16  number of 32-bit words to load; sampled on an accepted start.
REQ-007 s_data_i  in  8  byte stream data.
REQ-008 s_valid_i  in  1  byte valid; s_ready_o  out  1  byte accept; transfer occurs when both are high on a rising edge.
REQ-009 wbm_adr_o  out  32, wbm_dat_o  out  32, wbm_sel_o  out  4, wbm_we_o  out  1, wbm_cyc_o  out  1, wbm_stb_o  out  1: Wishbone classic master outputs.
REQ-010 wbm_ack_i  in  1  Wishbone acknowledge.
REQ-011 busy_o  out  1  high from accepted start until done pulse; done_o  out  1  single-cycle completion pulse.
REQ-012 checksum_o  out  32  running byte sum (see Configuration).

Function
REQ-013 FSM states SHALL be IDLE, FILL, WRITE, DONE.
REQ-014 IDLE: start_i=1 SHALL latch len_i, clear word index and byte count, and enter FILL (or DONE if len_i=0); start_i in any other state SHALL be ignored.
REQ-015 s_ready_o SHALL be high only in FILL; one byte accepted per cycle max.
REQ-016 Bytes SHALL be packed little-endian: byte 0 -> [7:0], byte 3 -> [31:24].
REQ-017 Acceptance of the 4th byte SHALL transition to WRITE on the next edge with cyc=stb=we=1, sel=4'hF, dat=packed word.
REQ-018 wbm_adr_o SHALL be BASE_ADR + 4*(word index mod WORDS); index beyond WORDS-1 SHALL wrap to 0.
REQ-019 In WRITE, adr/dat/sel/we/cyc/stb SHALL be held stable until the cycle wbm_ack_i=1 is sampled; any ack latency SHALL be tolerated.
REQ-020 On sampled ack: cyc, stb, we SHALL drop to 0 on the same edge; word index increments; go to FILL if words remain, else DONE.
REQ-021 cyc/stb SHALL be low for at least one cycle between consecutive writes.
REQ-022 wbm_ack_i while cyc=0 SHALL be ignored.
REQ-023 DONE SHALL assert done_o for exactly one cycle, then return to IDLE; busy_o SHALL be 0 in the cycle done_o is high.
REQ-024 Stalled stream (s_valid_i=0) SHALL hold FILL indefinitely with partial word preserved.
REQ-025 Latency: last byte accepted at edge N -> stb high after N; ack sampled at edge M -> done_o high after edge M+1.

Reset
REQ-026 wb_rst_ni=0 SHALL immediately force IDLE, cyc=stb=we=0, s_ready_o=0, busy_o=0, done_o=0, sel=0, adr=0, dat=0, checksum_o=0, counters 0, regardless of state.
REQ-027 Reset mid-WRITE SHALL abandon the cycle with no retry after release.

Configuration
REQ-028 Macro LOADER_CHECKSUM_EN: defined -> checksum_o SHALL be the 32-bit wrapping sum of all bytes accepted since the last accepted start (cleared on start); undefined -> checksum_o SHALL be constant 0 and no summing logic present.

Verification
REQ-029 Reset, start with len_i=1, bytes 11,22,33,44 -> one write adr=BASE_ADR, dat=32'h44332211, sel=F; done_o one cycle.
REQ-030 len_i=3, slave ack delay 0/1/5 cycles -> adr BASE, +4, +8, outputs stable until ack, cyc low >=1 cycle between writes.
REQ-031 len_i=0 -> no Wishbone cycle, s_ready_o never high, done_o one cycle after start.
REQ-032 WORDS=4, len_i=6 -> addresses +0,+4,+8,+C,+0,+4.
REQ-033 Assert wb_rst_ni=0 while stb=1 awaiting ack -> cyc/stb 0 without clock edge; after release no further writes, busy_o=0.
REQ-034 With LOADER_CHECKSUM_EN, bytes FF,FF,FF,FF -> checksum_o=32'h3FC; without -> 0; start_i during busy ignored in both builds.

Source files
------------

// File: rtl/wb_byte_loader.sv
// wb_byte_loader: packs a little-endian byte stream into 32-bit Wishbone writes.
// Define LOADER_CHECKSUM_EN to enable the running byte checksum on checksum_o.
module wb_byte_loader #(
  parameter logic [31:0] BASE_ADR = 32'h0000_0000,
  parameter int unsigned WORDS    = 256
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        start_i,
  input  logic [15:0] len_i,
  input  logic [7:0]  s_data_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] checksum_o
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } state_t;

  localparam logic [15:0] IDX_MASK = 16'(WORDS - 1);

  state_t      state_q, state_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic        done_q;
  logic        take;
  logic        wr;

  assign s_ready_o = (state_q == FILL);
  assign take      = s_ready_o & s_valid_i;
  assign wr        = (state_q == WRITE);

  // Bus outputs decode straight from state so reset clears them at once.
  assign wbm_cyc_o = wr;
  assign wbm_stb_o = wr;
  assign wbm_we_o  = wr;
  assign wbm_sel_o = wr ? 4'hF : 4'h0;
  assign wbm_dat_o = wr ? word_q : 32'h0;
  assign wbm_adr_o = wr ? BASE_ADR + {14'h0, idx_q & IDX_MASK, 2'b00}
                        : 32'h0;

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          rem_d   = len_i;
          idx_d   = 16'h0;
          cnt_d   = 2'd0;
          word_d  = 32'h0;
          state_d = (len_i == 16'h0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (take) begin
          word_d[{cnt_q, 3'b000} +: 8] = s_data_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        if (wbm_ack_i) begin
          idx_d   = idx_q + 16'd1;
          rem_d   = rem_q - 16'd1;
          state_d = (rem_q == 16'd1) ? DONE : FILL;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      rem_q   <= 16'h0;
      idx_q   <= 16'h0;
      cnt_q   <= 2'd0;
      word_q  <= 32'h0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      done_q  <= (state_q == DONE);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sum_q <= 32'h0;
    end else if (state_q == IDLE && start_i) begin
      sum_q <= 32'h0;
    end else if (take) begin
      sum_q <= sum_q + {24'h0, s_data_i};
    end
  end

  assign checksum_o = sum_q;
`else
  assign checksum_o = 32'h0;
`endif

endmodule

// File: tb/tb_wb_byte_loader.sv
// tb_wb_byte_loader: scoreboard bench for wb_byte_loader (WORDS=4).
// A Wishbone slave model pops expected writes and applies per-write ack delays.
module tb_wb_byte_loader;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          WORDS = 4;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni;
  logic        start_i;
  logic [15:0] len_i;
  logic [7:0]  s_data_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_ack_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] checksum_o;

  logic slave_ack;
  logic stray_ack;
  assign wbm_ack_i = slave_ack | stray_ack;

  wb_byte_loader #(
    .BASE_ADR(BASE),
    .WORDS   (WORDS)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .start_i   (start_i),
    .len_i     (len_i),
    .s_data_i  (s_data_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_ack_i (wbm_ack_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .checksum_o(checksum_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
  } wr_t;

  wr_t         exp_q[$];
  int          dly_q[$];
  int          passed = 0;
  int          total  = 0;
  int          writes = 0;
  time         last_ack_t = 0;
  logic [31:0] exp_sum = 32'h0;

  function automatic wr_t exp_wr(input int idx, input logic [31:0] w);
    wr_t r;
    r.adr = BASE + 32'((idx % WORDS) * 4);
    r.dat = w;
    return r;
  endfunction

  function automatic logic [31:0] ck_exp();
`ifdef LOADER_CHECKSUM_EN
    return exp_sum;
`else
    return 32'h0;
`endif
  endfunction

  // Wishbone slave model and scoreboard
  initial begin : slave
    wr_t  e;
    int   d;
    int   n;
    bit   stable;
    slave_ack = 1'b0;
    forever begin
      @(negedge wb_clk_i);
      if (wbm_cyc_o && wbm_stb_o) begin
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_write: adr=%h dat=%h, want no write",
                   wbm_adr_o, wbm_dat_o);
          e = '0;
        end else begin
          e = exp_q.pop_front();
          if ({wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o} !==
              {e.adr, e.dat, 4'hF, 1'b1}) begin
            $display("FAIL write: adr=%h dat=%h sel=%h we=%b, want adr=%h dat=%h sel=f we=1",
                     wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, e.adr, e.dat);
          end else begin
            passed++;
          end
        end
        d = (dly_q.size() != 0) ? dly_q.pop_front() : 0;
        n = 0;
        stable = 1'b1;
        while (n < d && wb_rst_ni) begin
          @(negedge wb_clk_i);
          n++;
          if (wb_rst_ni && ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o} !== 7'h7F
                            || wbm_adr_o !== e.adr || wbm_dat_o !== e.dat))
            stable = 1'b0;
        end
        if (wb_rst_ni) begin
          total++;
          if (!stable) $display("FAIL hold: outputs changed before ack, want stable");
          else passed++;
          slave_ack = 1'b1;
          @(posedge wb_clk_i);
          last_ack_t = $time;
          @(negedge wb_clk_i);
          slave_ack = 1'b0;
          writes++;
          total++;
          if ({wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 3'b000) begin
            $display("FAIL drop: cyc/stb/we=%b after ack, want 000",
                     {wbm_cyc_o, wbm_stb_o, wbm_we_o});
          end else begin
            passed++;
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    s_data_i  = b;
    s_valid_i = 1'b1;
    while (!s_ready_o && t < 200) begin
      @(negedge wb_clk_i);
      t++;
    end
    if (t >= 200) begin
      total++;
      $display("FAIL ready_timeout: s_ready_o=0 for 200 cycles, want 1");
      s_valid_i = 1'b0;
      return;
    end
    @(posedge wb_clk_i);
    exp_sum = exp_sum + {24'h0, b};
    #1 s_valid_i = 1'b0;
  endtask

  task automatic send_word(input int idx, input logic [31:0] w);
    exp_q.push_back(exp_wr(idx, w));
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
  endtask

  task automatic do_start(input logic [15:0] l);
    exp_sum = 32'h0;
    start_i = 1'b1;
    len_i   = l;
    @(posedge wb_clk_i);
    #1 start_i = 1'b0;
  endtask

  task automatic wait_done(output bit seen, output time t);
    seen = 1'b0;
    t    = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge wb_clk_i);
      if (done_o) begin
        seen = 1'b1;
        t    = $time;
        break;
      end
    end
  endtask

  task automatic test_reset;
    wb_rst_ni = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    total++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, s_ready_o, busy_o, done_o} !== 6'b0)
      $display("FAIL reset_ctl: %b, want 000000",
               {wbm_cyc_o, wbm_stb_o, wbm_we_o, s_ready_o, busy_o, done_o});
    else passed++;
    total++;
    if ({wbm_sel_o, wbm_adr_o, wbm_dat_o, checksum_o} !== 100'h0)
      $display("FAIL reset_data: sel=%h adr=%h dat=%h ck=%h, want 0",
               wbm_sel_o, wbm_adr_o, wbm_dat_o, checksum_o);
    else passed++;
    wb_rst_ni = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    total++;
    if ({busy_o, s_ready_o, wbm_cyc_o} !== 3'b000)
      $display("FAIL reset_release: busy/ready/cyc=%b, want 000",
               {busy_o, s_ready_o, wbm_cyc_o});
    else passed++;
  endtask

  task automatic test_single;
    bit  seen;
    time t;
    do_start(16'd1);
    send_word(0, 32'h4433_2211);
    wait_done(seen, t);
    total++;
    if (!seen) $display("FAIL single_done: no done_o, want pulse");
    else passed++;
    total++;
    if (t - last_ack_t != 15)
      $display("FAIL single_latency: %0d, want 15", t - last_ack_t);
    else passed++;
    total++;
    if (busy_o !== 1'b0) $display("FAIL single_busy: %b, want 0", busy_o);
    else passed++;
    total++;
    if (checksum_o !== ck_exp())
      $display("FAIL single_ck: %h, want %h", checksum_o, ck_exp());
    else passed++;
    @(negedge wb_clk_i);
    total++;
    if (done_o !== 1'b0) $display("FAIL single_pulse: done=%b, want 0", done_o);
    else passed++;
    total++;
    if (writes != 1 || exp_q.size() != 0)
      $display("FAIL single_count: writes=%0d left=%0d, want 1 0", writes, exp_q.size());
    else passed++;
  endtask

  task automatic test_ack_delays;
    bit          seen;
    time         t;
    int          w0;
    logic [31:0] w;
    w0 = writes;
    dly_q = '{0, 1, 5};
    do_start(16'd3);
    send_word(0, $urandom);
    w = $urandom;
    exp_q.push_back(exp_wr(1, w));
    send_byte(w[7:0]);
    repeat (4) @(negedge wb_clk_i);
    total++;
    if ({s_ready_o, busy_o, wbm_cyc_o} !== 3'b110)
      $display("FAIL stall_hold: ready/busy/cyc=%b, want 110",
               {s_ready_o, busy_o, wbm_cyc_o});
    else passed++;
    for (int b = 1; b < 4; b++) send_byte(w[8*b +: 8]);
    send_word(2, $urandom);
    wait_done(seen, t);
    total++;
    if (!seen || t - last_ack_t != 15)
      $display("FAIL delay_done: seen=%b dt=%0d, want 1 15", seen, t - last_ack_t);
    else passed++;
    total++;
    if (writes - w0 != 3 || exp_q.size() != 0)
      $display("FAIL delay_count: writes=%0d left=%0d, want 3 0", writes - w0, exp_q.size());
    else passed++;
    total++;
    if (checksum_o !== ck_exp())
      $display("FAIL delay_ck: %h, want %h", checksum_o, ck_exp());
    else passed++;
  endtask

  task automatic test_len_zero;
    int w0;
    w0 = writes;
    @(negedge wb_clk_i);
    do_start(16'd0);
    @(negedge wb_clk_i);
    total++;
    if ({done_o, busy_o, s_ready_o, wbm_cyc_o} !== 4'b0100)
      $display("FAIL zero_first: done/busy/ready/cyc=%b, want 0100",
               {done_o, busy_o, s_ready_o, wbm_cyc_o});
    else passed++;
    @(negedge wb_clk_i);
    total++;
    if ({done_o, busy_o, s_ready_o, wbm_cyc_o} !== 4'b1000)
      $display("FAIL zero_done: done/busy/ready/cyc=%b, want 1000",
               {done_o, busy_o, s_ready_o, wbm_cyc_o});
    else passed++;
    @(negedge wb_clk_i);
    total++;
    if (done_o !== 1'b0 || writes != w0 || checksum_o !== 32'h0)
      $display("FAIL zero_after: done=%b writes=%0d ck=%h, want 0 %0d 0",
               done_o, writes, checksum_o, w0);
    else passed++;
  endtask

  task automatic test_wrap;
    bit  seen;
    time t;
    int  w0;
    w0 = writes;
    dly_q = '{2, 0, 1, 0, 3, 0};
    do_start(16'd6);
    for (int i = 0; i < 6; i++) send_word(i, $urandom);
    wait_done(seen, t);
    total++;
    if (!seen || writes - w0 != 6 || exp_q.size() != 0)
      $display("FAIL wrap: seen=%b writes=%0d left=%0d, want 1 6 0",
               seen, writes - w0, exp_q.size());
    else passed++;
  endtask

  task automatic test_start_busy;
    bit  seen;
    time t;
    int  w0;
    w0 = writes;
    @(negedge wb_clk_i);
    stray_ack = 1'b1;
    @(negedge wb_clk_i);
    stray_ack = 1'b0;
    @(negedge wb_clk_i);
    total++;
    if ({busy_o, wbm_cyc_o, done_o} !== 3'b000 || writes != w0)
      $display("FAIL stray_ack: busy/cyc/done=%b, want 000",
               {busy_o, wbm_cyc_o, done_o});
    else passed++;
    do_start(16'd1);
    exp_q.push_back(exp_wr(0, 32'hFFFF_FFFF));
    send_byte(8'hFF);
    send_byte(8'hFF);
    start_i = 1'b1;
    len_i   = 16'd5;
    @(posedge wb_clk_i);
    #1 start_i = 1'b0;
    send_byte(8'hFF);
    send_byte(8'hFF);
    wait_done(seen, t);
    total++;
`ifdef LOADER_CHECKSUM_EN
    if (checksum_o !== 32'h0000_03FC)
      $display("FAIL ck_ff: %h, want 000003fc", checksum_o);
    else passed++;
`else
    if (checksum_o !== 32'h0)
      $display("FAIL ck_off: %h, want 00000000", checksum_o);
    else passed++;
`endif
    repeat (10) @(negedge wb_clk_i);
    total++;
    if (!seen || busy_o !== 1'b0 || writes - w0 != 1 || exp_q.size() != 0)
      $display("FAIL busy_start: seen=%b busy=%b writes=%0d, want 1 0 1",
               seen, busy_o, writes - w0);
    else passed++;
  endtask

  task automatic test_reset_mid_write;
    bit got;
    bit bad;
    int w0;
    w0 = writes;
    dly_q = '{1000};
    do_start(16'd2);
    send_word(0, 32'hCAFE_F00D);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (wbm_stb_o) begin
        got = 1'b1;
        break;
      end
      @(negedge wb_clk_i);
    end
    total++;
    if (!got) $display("FAIL rst_stb: stb never high, want 1");
    else passed++;
    @(negedge wb_clk_i);
    #2 wb_rst_ni = 1'b0;
    #1;
    total++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o} !== 4'b0000)
      $display("FAIL rst_async: cyc/stb/we/busy=%b, want 0000",
               {wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o});
    else passed++;
    repeat (2) @(negedge wb_clk_i);
    #2 wb_rst_ni = 1'b1;
    dly_q.delete();
    s_data_i  = 8'h5A;
    s_valid_i = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge wb_clk_i);
      if (wbm_cyc_o || wbm_stb_o || s_ready_o || busy_o) bad = 1'b1;
    end
    s_valid_i = 1'b0;
    total++;
    if (bad || writes != w0 || exp_q.size() != 0 || checksum_o !== 32'h0)
      $display("FAIL rst_no_retry: bad=%b writes=%0d ck=%h, want 0 %0d 0",
               bad, writes, checksum_o, w0);
    else passed++;
  endtask

  initial begin
    wb_rst_ni = 1'b0;
    start_i   = 1'b0;
    len_i     = 16'h0;
    s_data_i  = 8'h0;
    s_valid_i = 1'b0;
    stray_ack = 1'b0;
    test_reset;
    test_single;
    test_ack_delays;
    test_len_zero;
    test_wrap;
    test_start_busy;
    test_reset_mid_write;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
